// File: rtl/vec_rf_rd_seq_if.sv
// Command, register-file read and packet-output bundle for the vector RF read sequencer.
// The slave modport is the sequencer side; master is the command issuer / RF / consumer side.
interface vec_rf_rd_seq_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int OFF_BITS   = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_vs1;
  logic [ADDR_WIDTH-1:0] cmd_vs2;
  logic                  cmd_use2;
  logic [OFF_BITS:0]     cmd_npkt;

  logic                  rd_en_1;
  logic                  rd_en_2;
  logic [ADDR_WIDTH-1:0] rd_addr_1;
  logic [ADDR_WIDTH-1:0] rd_addr_2;
  logic [OFF_BITS-1:0]   rd_off_1;
  logic [OFF_BITS-1:0]   rd_off_2;
  logic [DATA_WIDTH-1:0] rd_data_1;
  logic [DATA_WIDTH-1:0] rd_data_2;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data_1;
  logic [DATA_WIDTH-1:0] out_data_2;
  logic                  out_last;

  logic                  busy;
  logic                  done;

  modport slave (
    input  cmd_valid, cmd_vs1, cmd_vs2, cmd_use2, cmd_npkt,
    input  rd_data_1, rd_data_2, out_ready,
    output cmd_ready, rd_en_1, rd_en_2, rd_addr_1, rd_addr_2, rd_off_1, rd_off_2,
    output out_valid, out_data_1, out_data_2, out_last, busy, done
  );

  modport master (
    output cmd_valid, cmd_vs1, cmd_vs2, cmd_use2, cmd_npkt,
    output rd_data_1, rd_data_2, out_ready,
    input  cmd_ready, rd_en_1, rd_en_2, rd_addr_1, rd_addr_2, rd_off_1, rd_off_2,
    input  out_valid, out_data_1, out_data_2, out_last, busy, done
  );
endinterface

// File: rtl/vec_rf_rd_seq.sv
// Streams npkt packet pairs out of one or two vector registers through a 2-entry output FIFO,
// issuing register-file reads only when the FIFO is guaranteed room for the returning data.
module vec_rf_rd_seq #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 64,
  parameter int OFF_BITS     = 8,
  parameter int PACK_PER_REG = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vec_rf_rd_seq_if.slave        bus
);

  localparam logic [OFF_BITS:0] LP_MAX = (OFF_BITS+1)'(PACK_PER_REG);
  localparam logic [OFF_BITS:0] LP_ONE = (OFF_BITS+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_rdy;
  logic [ADDR_WIDTH-1:0] r_vs1;
  logic [ADDR_WIDTH-1:0] r_vs2;
  logic                  r_use2;
  logic [OFF_BITS:0]     r_npkt;
  logic [OFF_BITS:0]     r_cnt;
  logic                  r_inflight;
  logic                  r_infl_last;
  logic                  r_done;

  logic [DATA_WIDTH-1:0] r_fifo_d1 [2];
  logic [DATA_WIDTH-1:0] r_fifo_d2 [2];
  logic [1:0]            r_fifo_last;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;

  logic                  w_cmd_ready;
  logic                  w_accept;
  logic [OFF_BITS:0]     w_npkt;
  logic                  w_out_valid;
  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_occ;
  logic                  w_issue;
  logic                  w_issue_last;
  logic                  w_pop_last;

  assign w_cmd_ready  = r_rdy && (r_state == S_IDLE);
  assign w_accept     = bus.cmd_valid && w_cmd_ready;
  assign w_npkt       = (bus.cmd_npkt > LP_MAX) ? LP_MAX : bus.cmd_npkt;
  assign w_out_valid  = (r_count != 2'd0);
  assign w_pop        = w_out_valid && bus.out_ready;
  assign w_push       = r_inflight;
  // Occupancy the FIFO will have once the in-flight read lands and this cycle's pop retires.
  assign w_occ        = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue      = (r_state == S_ISSUE) && (w_occ < 3'd2);
  assign w_issue_last = w_issue && (r_cnt == (r_npkt - LP_ONE));
  assign w_pop_last   = w_pop && r_fifo_last[r_rptr];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && (w_npkt != '0)) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_issue_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rdy       <= 1'b0;
      r_vs1       <= '0;
      r_vs2       <= '0;
      r_use2      <= 1'b0;
      r_npkt      <= '0;
      r_cnt       <= '0;
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
      r_done      <= 1'b0;
      r_fifo_last <= '0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_rdy       <= 1'b1;
      r_done      <= w_pop_last || (w_accept && (w_npkt == '0));
      r_inflight  <= w_issue;
      r_infl_last <= w_issue_last;
      if (w_accept) begin
        r_vs1  <= bus.cmd_vs1;
        r_vs2  <= bus.cmd_vs2;
        r_use2 <= bus.cmd_use2;
        r_npkt <= w_npkt;
        r_cnt  <= '0;
      end else if (w_issue) begin
        r_cnt <= r_cnt + LP_ONE;
      end
      if (w_push) begin
        r_fifo_last[r_wptr] <= r_infl_last;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Packet payload is not reset; it is only ever observed through out_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_d1[r_wptr] <= bus.rd_data_1;
      r_fifo_d2[r_wptr] <= r_use2 ? bus.rd_data_2 : '0;
    end
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;

  assign bus.rd_en_1    = w_issue;
  assign bus.rd_addr_1  = w_issue ? r_vs1 : '0;
  assign bus.rd_off_1   = w_issue ? r_cnt[OFF_BITS-1:0] : '0;
  assign bus.rd_en_2    = w_issue && r_use2;
  assign bus.rd_addr_2  = (w_issue && r_use2) ? r_vs2 : '0;
  assign bus.rd_off_2   = (w_issue && r_use2) ? r_cnt[OFF_BITS-1:0] : '0;

  assign bus.out_valid  = w_out_valid;
  assign bus.out_data_1 = w_out_valid ? r_fifo_d1[r_rptr] : '0;
  assign bus.out_data_2 = w_out_valid ? r_fifo_d2[r_rptr] : '0;
  assign bus.out_last   = w_out_valid && r_fifo_last[r_rptr];

endmodule

// File: tb/tb_vec_rf_rd_seq.sv
// Directed bench for vec_rf_rd_seq: behavioural register file, packet scoreboard and cycle-exact checks.
module tb_vec_rf_rd_seq;
  localparam int AW  = 5;
  localparam int DW  = 64;
  localparam int OB  = 8;
  localparam int PPR = 256;

  typedef struct packed {
    logic [63:0] d1;
    logic [63:0] d2;
    logic        last;
  } pkt_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_rd1  = 0;
  int   n_rd2  = 0;
  int   n_done = 0;
  pkt_t sb[$];

  vec_rf_rd_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFF_BITS(OB)) bus ();

  vec_rf_rd_seq #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFF_BITS(OB), .PACK_PER_REG(PPR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rf_val(input int port, input logic [4:0] a, input logic [7:0] o);
    return {16'hC0DE, 8'(port), 3'b000, a, 8'h00, o, 8'h5A, ~o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register file: strobe seen during a cycle, data presented for the whole next cycle.
  logic       s_en1, s_en2;
  logic [4:0] s_a1, s_a2;
  logic [7:0] s_o1, s_o2;
  always @(negedge clk) begin
    s_en1 = bus.rd_en_1; s_a1 = bus.rd_addr_1; s_o1 = bus.rd_off_1;
    s_en2 = bus.rd_en_2; s_a2 = bus.rd_addr_2; s_o2 = bus.rd_off_2;
  end
  always @(posedge clk) begin
    #1;
    bus.rd_data_1 = s_en1 ? rf_val(1, s_a1, s_o1) : 64'hDEAD_0000_DEAD_0001;
    bus.rd_data_2 = s_en2 ? rf_val(2, s_a2, s_o2) : 64'hDEAD_0000_DEAD_0002;
  end

  always @(negedge clk) begin
    pkt_t e;
    if (bus.rd_en_1) n_rd1++;
    if (bus.rd_en_2) n_rd2++;
    if (bus.done) n_done++;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pkt", 64'(bus.out_data_1), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("out_data_1", bus.out_data_1, e.d1);
        chk("out_data_2", bus.out_data_2, e.d2);
        chk("out_last", 64'(bus.out_last), 64'(e.last));
      end
    end
  end

  task automatic send(input logic [4:0] v1, input logic [4:0] v2, input logic u2, input logic [8:0] n);
    int   ne;
    pkt_t p;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_vs1   = v1;
    bus.cmd_vs2   = v2;
    bus.cmd_use2  = u2;
    bus.cmd_npkt  = n;
    ne = (int'(n) > PPR) ? PPR : int'(n);
    for (int k = 0; k < ne; k++) begin
      p.d1   = rf_val(1, v1, 8'(k));
      p.d2   = u2 ? rf_val(2, v2, 8'(k)) : 64'd0;
      p.last = (k == ne - 1);
      sb.push_back(p);
    end
    @(negedge clk);
    chk("cmd_ready_at_accept", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  b_rd1, b_rd2, b_done;
    bit  seen;
    bit  en;
    bus.cmd_valid = 1'b0;
    bus.cmd_vs1   = '0;
    bus.cmd_vs2   = '0;
    bus.cmd_use2  = 1'b0;
    bus.cmd_npkt  = '0;
    bus.out_ready = 1'b1;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_rd_en_1", 64'(bus.rd_en_1), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-rate stream, cycle-exact timing.
    b_rd1 = n_rd1;
    send(5'd3, 5'd7, 1'b1, 9'd4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      en = (c <= 4);
      chk("s17_rd_en_1", 64'(bus.rd_en_1), 64'(en));
      chk("s17_rd_en_2", 64'(bus.rd_en_2), 64'(en));
      chk("s17_rd_addr_1", 64'(bus.rd_addr_1), en ? 64'd3 : 64'd0);
      chk("s17_rd_addr_2", 64'(bus.rd_addr_2), en ? 64'd7 : 64'd0);
      chk("s17_rd_off_1", 64'(bus.rd_off_1), en ? 64'(c - 1) : 64'd0);
      chk("s17_out_valid", 64'(bus.out_valid), 64'(c >= 3 && c <= 6));
      chk("s17_out_last", 64'(bus.out_last), 64'(c == 6));
      chk("s17_done", 64'(bus.done), 64'(c == 7));
      chk("s17_busy", 64'(bus.busy), 64'(c <= 6));
    end
    chk("s17_reads", 64'(n_rd1 - b_rd1), 64'd4);
    chk("s17_sb_empty", 64'(sb.size()), 64'd0);

    // Back-pressure: FIFO fills with two entries and issue stalls.
    b_rd1 = n_rd1;
    send(5'd11, 5'd12, 1'b1, 9'd4);
    bus.out_ready = 1'b0;
    repeat (8) @(negedge clk);
    chk("s18_reads_stalled", 64'(n_rd1 - b_rd1), 64'd2);
    chk("s18_out_valid", 64'(bus.out_valid), 64'd1);
    chk("s18_head", bus.out_data_1, rf_val(1, 5'd11, 8'd0));
    chk("s18_rd_en_1", 64'(bus.rd_en_1), 64'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done("s18_done_seen", 40);
    chk("s18_reads", 64'(n_rd1 - b_rd1), 64'd4);
    chk("s18_sb_empty", 64'(sb.size()), 64'd0);

    // Single port: second read port stays idle, out_data_2 zero.
    b_rd1 = n_rd1; b_rd2 = n_rd2;
    send(5'd2, 5'd9, 1'b0, 9'd2);
    wait_done("s19_done_seen", 40);
    chk("s19_rd2_count", 64'(n_rd2 - b_rd2), 64'd0);
    chk("s19_rd1_count", 64'(n_rd1 - b_rd1), 64'd2);
    chk("s19_sb_empty", 64'(sb.size()), 64'd0);

    // Zero-length command.
    b_rd1 = n_rd1;
    send(5'd4, 5'd4, 1'b1, 9'd0);
    @(negedge clk);
    chk("s20_done_t1", 64'(bus.done), 64'd1);
    chk("s20_busy_t1", 64'(bus.busy), 64'd0);
    chk("s20_rd_en_t1", 64'(bus.rd_en_1), 64'd0);
    @(negedge clk);
    chk("s20_done_t2", 64'(bus.done), 64'd0);
    chk("s20_busy_t2", 64'(bus.busy), 64'd0);
    chk("s20_reads", 64'(n_rd1 - b_rd1), 64'd0);

    // Over-length request clamps to a full register.
    b_rd1 = n_rd1;
    send(5'd17, 5'd30, 1'b1, 9'd300);
    wait_done("s21_done_seen", 400);
    chk("s21_reads", 64'(n_rd1 - b_rd1), 64'd256);
    chk("s21_sb_empty", 64'(sb.size()), 64'd0);

    // Random consumer stalls.
    send(5'd9, 5'd10, 1'b1, 9'd20);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    bus.out_ready = 1'b1;
    chk("rnd_done_seen", 64'(seen), 64'd1);
    chk("rnd_sb_empty", 64'(sb.size()), 64'd0);

    // Reset in the middle of a command.
    send(5'd5, 5'd6, 1'b1, 9'd8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("s22_out_valid", 64'(bus.out_valid), 64'd0);
    chk("s22_rd_en_1", 64'(bus.rd_en_1), 64'd0);
    chk("s22_rd_en_2", 64'(bus.rd_en_2), 64'd0);
    chk("s22_rd_off_1", 64'(bus.rd_off_1), 64'd0);
    chk("s22_busy", 64'(bus.busy), 64'd0);
    chk("s22_done", 64'(bus.done), 64'd0);
    chk("s22_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("s22_out_data_1", bus.out_data_1, 64'd0);
    b_done = n_done;
    b_rd1  = n_rd1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("s22_ready_before_edge", 64'(bus.cmd_ready), 64'd0);
    @(negedge clk);
    chk("s22_ready_after_edge", 64'(bus.cmd_ready), 64'd1);
    repeat (6) @(negedge clk);
    chk("s22_no_done", 64'(n_done - b_done), 64'd0);
    chk("s22_no_reads", 64'(n_rd1 - b_rd1), 64'd0);
    chk("s22_no_output", 64'(bus.out_valid), 64'd0);
    send(5'd1, 5'd2, 1'b1, 9'd3);
    @(negedge clk);
    chk("s22_restart_en", 64'(bus.rd_en_1), 64'd1);
    chk("s22_restart_off", 64'(bus.rd_off_1), 64'd0);
    wait_done("s22_restart_done", 40);
    chk("s22_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vec_rf_rd_seq.md
VEC_RF_RD_SEQ -- requirements
Module: vec_rf_rd_seq

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WIDTH 5, vector register index width; DATA_WIDTH 64, packet width; OFF_BITS 8, packet-offset width; PACK_PER_REG 256, packets per vector register.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_vs1  in  ADDR_WIDTH  source register on port 1
- cmd_vs2  in  ADDR_WIDTH  source register on port 2
- cmd_use2  in  1  port 2 read enable for this command
- cmd_npkt  in  OFF_BITS+1  packets to stream, 0..PACK_PER_REG
- rd_en_1, rd_en_2  out  1  register-file read strobes
- rd_addr_1, rd_addr_2  out  ADDR_WIDTH  register-file read addresses
- rd_off_1, rd_off_2  out  OFF_BITS  register-file read offsets
- rd_data_1, rd_data_2  in  DATA_WIDTH  register-file read data, valid the cycle after the strobe
- out_valid  out  1  packet pair available
- out_ready  in  1  consumer accepts
- out_data_1, out_data_2  out  DATA_WIDTH  packet pair
- out_last  out  1  final packet of command
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

Function
REQ-003 States: IDLE, ISSUE, DRAIN; cmd_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-004 Accept in IDLE on cmd_valid&cmd_ready: latch vs1, vs2, use2, npkt; clear issue counter; npkt>0 -> ISSUE; npkt==0 -> done pulse next cycle, stay IDLE, no reads.
REQ-005 cmd_npkt>PACK_PER_REG SHALL be clamped to PACK_PER_REG.
REQ-006 Port 1 read issued in cycle N: rd_en_1=1, rd_addr_1=vs1, rd_off_1=issue counter; port 2 identical with vs2 only when use2, else rd_en_2=0; counter increments per issue.
REQ-007 Output buffer: 2-entry FIFO of {data_1, data_2, last}; rd_data captured one cycle after the issue and pushed that cycle; out_data_2 SHALL be 0 when use2=0.
REQ-008 Issue permitted iff state==ISSUE and (fifo_count + inflight - pop) < 2, where pop = out_valid&out_ready this cycle; inflight = read issued the previous cycle.
REQ-009 With out_ready held high, SHALL sustain one packet per cycle; first out_valid at accept cycle T+3 (issue T+1, data T+2, FIFO head T+3).
REQ-010 out_valid SHALL equal FIFO non-empty; head data stable while out_valid&!out_ready.
REQ-011 The entry from issue counter npkt-1 SHALL carry last=1; after that issue, ISSUE -> DRAIN.
REQ-012 DRAIN -> IDLE when the last entry pops; done SHALL pulse in the cycle after that pop; new command acceptable the same cycle done is high.
REQ-013 Push and pop in the same cycle SHALL leave fifo_count unchanged; FIFO never overflows or underflows.
REQ-014 rd_addr_*/rd_off_* SHALL be 0 when their rd_en is 0.

Reset
REQ-015 rst_n low SHALL asynchronously force state IDLE, counters and FIFO empty, in-flight read discarded, all outputs 0 except cmd_ready, which goes to 1 after the first edge following deassertion; the in-flight read data arriving post-reset SHALL be ignored.
REQ-016 Reset mid-command SHALL produce no done pulse and no further reads.

Verification
REQ-017 vs1=3, vs2=7, use2=1, npkt=4, out_ready=1 -> rd_off 0,1,2,3 on cycles T+1..T+4; out_valid T+3..T+6; out_last at T+6; done at T+7.
REQ-018 npkt=4, out_ready low T+1..T+8 -> at most 2 reads issued plus none further; FIFO holds offsets 0,1; release -> all 4 packets in order, no loss or duplicates.
REQ-019 use2=0, npkt=2 -> rd_en_2 never high; out_data_2=0 on both packets.
REQ-020 npkt=0 -> no rd_en; done one cycle after accept; busy stays 0.
REQ-021 npkt=300 -> exactly 256 packets, offsets 0..255, last at offset 255.
REQ-022 rst_n low at T+3 of an npkt=8 command -> outputs 0 immediately; no done; next command streams from offset 0.
